// File: rtl/hamle_toplayici.sv
// ============================================================================
// hamle_toplayici -- round sequencer feeding the clash scorer.
//
// Collects one 2-bit right/down step pair per player (P1, P2, P3 in turn)
// from the shared move input and packs them into 6-bit step vectors. It also
// supplies a 4-bit pseudo-random hidden number per round and consumes the
// scorer's combinational result during the single evaluation cycle. Per game
// it keeps the round count, per-player win counts (saturating at 7) and a
// cumulative score (saturating at 255).
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   basla          start-game pulse (honoured in BOSTA and BITTI only)
//   hamle_gecerli  one-cycle move strobe from the current player
//   hamle_sag      right steps of the current move
//   hamle_asagi    down steps of the current move
//   kazanan        winner from scorer (0 = none, 1..3)
//   toplam_puan    round score from scorer
//   sag_adimlar    packed right steps: P1 [5:4], P2 [3:2], P3 [1:0]
//   asagi_adimlar  packed down steps, same packing
//   sayi           hidden number for the current round
//   oyuncu_sira    player expected next (1..3), 0 when not collecting
//   tur_gecerli    high for the one evaluation cycle of each round
//   tur_no         completed rounds in the current game
//   toplam_skor    cumulative round score, saturating at 255
//   galibiyet1/2/3 per-player round wins, saturating at 7
//   oyun_bitti     high while the game is over (BITTI)
//
// Optional feature macro: HAMLE_ZAMAN_ASIMI_EN
//   When defined, a player that stays idle for ZAMAN_SINIRI cycles in TOPLA
//   is skipped with a 00/00 move. When undefined, TOPLA waits indefinitely.
// ============================================================================
module hamle_toplayici #(
    parameter int         TUR_SAYISI   = 4,
    parameter logic [3:0] LFSR_TOHUM   = 4'b1011,
    parameter int         ZAMAN_SINIRI = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       basla,
    input  logic       hamle_gecerli,
    input  logic [1:0] hamle_sag,
    input  logic [1:0] hamle_asagi,
    input  logic [1:0] kazanan,
    input  logic [4:0] toplam_puan,
    output logic [5:0] sag_adimlar,
    output logic [5:0] asagi_adimlar,
    output logic [3:0] sayi,
    output logic [1:0] oyuncu_sira,
    output logic       tur_gecerli,
    output logic [3:0] tur_no,
    output logic [7:0] toplam_skor,
    output logic [2:0] galibiyet1,
    output logic [2:0] galibiyet2,
    output logic [2:0] galibiyet3,
    output logic       oyun_bitti
);

    localparam logic [1:0] BOSTA       = 2'd0;
    localparam logic [1:0] TOPLA       = 2'd1;
    localparam logic [1:0] DEGERLENDIR = 2'd2;
    localparam logic [1:0] BITTI       = 2'd3;

    // Reject configurations the counters cannot represent.
    if (TUR_SAYISI < 1 || TUR_SAYISI > 15 || ZAMAN_SINIRI < 1 ||
        LFSR_TOHUM == 4'b0000) begin : g_param_hata
        $error("hamle_toplayici: illegal parameter value");
    end

    logic [1:0] durum_q, durum_d;
    logic [3:0] lfsr_q, lfsr_d;
    logic [5:0] sag_q, sag_d;
    logic [5:0] asagi_q, asagi_d;
    logic [3:0] sayi_q, sayi_d;
    logic [1:0] sira_q, sira_d;
    logic [3:0] tur_q, tur_d;
    logic [7:0] skor_q, skor_d;
    logic [2:0] gal1_q, gal1_d;
    logic [2:0] gal2_q, gal2_d;
    logic [2:0] gal3_q, gal3_d;

    logic       adim_al;    // the current slot is filled this cycle
    logic [1:0] sag_yaz;
    logic [1:0] asagi_yaz;
    logic [8:0] skor_top;   // one spare bit to detect saturation
    logic [3:0] tur_yeni;

`ifdef HAMLE_ZAMAN_ASIMI_EN
    localparam int BOS_W = $clog2(ZAMAN_SINIRI + 1);
    logic [BOS_W-1:0] bos_q, bos_d;
    logic             zaman_doldu;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned; that is what keeps this block latch-free.
        durum_d   = durum_q;
        sag_d     = sag_q;
        asagi_d   = asagi_q;
        sayi_d    = sayi_q;
        sira_d    = sira_q;
        tur_d     = tur_q;
        skor_d    = skor_q;
        gal1_d    = gal1_q;
        gal2_d    = gal2_q;
        gal3_d    = gal3_q;
        skor_top  = {1'b0, skor_q} + 9'(toplam_puan);
        tur_yeni  = tur_q + 4'd1;
        // Fibonacci LFSR, x^4 + x^3 + 1: maximal length, never reaches zero.
        lfsr_d    = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        sag_yaz   = hamle_gecerli ? hamle_sag   : 2'b00;
        asagi_yaz = hamle_gecerli ? hamle_asagi : 2'b00;
`ifdef HAMLE_ZAMAN_ASIMI_EN
        bos_d       = bos_q;
        zaman_doldu = !hamle_gecerli && (bos_q == BOS_W'(ZAMAN_SINIRI - 1));
        adim_al     = hamle_gecerli || zaman_doldu;
`else
        adim_al     = hamle_gecerli;
`endif

        case (durum_q)
            BOSTA, BITTI: begin
                // A move strobe coinciding with basla is intentionally dropped.
                if (basla) begin
                    durum_d = TOPLA;
                    sag_d   = '0;
                    asagi_d = '0;
                    sira_d  = 2'd1;
                    sayi_d  = lfsr_q;
                    tur_d   = '0;
                    skor_d  = '0;
                    gal1_d  = '0;
                    gal2_d  = '0;
                    gal3_d  = '0;
`ifdef HAMLE_ZAMAN_ASIMI_EN
                    bos_d   = '0;
`endif
                end
            end

            TOPLA: begin
`ifdef HAMLE_ZAMAN_ASIMI_EN
                bos_d = adim_al ? '0 : bos_q + 1'b1;
`endif
                if (adim_al) begin
                    case (sira_q)
                        2'd1:    begin sag_d[5:4] = sag_yaz; asagi_d[5:4] = asagi_yaz; end
                        2'd2:    begin sag_d[3:2] = sag_yaz; asagi_d[3:2] = asagi_yaz; end
                        default: begin sag_d[1:0] = sag_yaz; asagi_d[1:0] = asagi_yaz; end
                    endcase
                    if (sira_q == 2'd3) begin
                        sira_d  = 2'd0;
                        durum_d = DEGERLENDIR;
                    end else begin
                        sira_d  = sira_q + 2'd1;
                    end
                end
            end

            DEGERLENDIR: begin
                // The scorer is combinational on our vectors, so its result
                // is valid within this cycle and is captured at its end.
                skor_d = skor_top[8] ? 8'hFF : skor_top[7:0];
                case (kazanan)
                    2'd1:    if (gal1_q != 3'd7) gal1_d = gal1_q + 3'd1;
                    2'd2:    if (gal2_q != 3'd7) gal2_d = gal2_q + 3'd1;
                    2'd3:    if (gal3_q != 3'd7) gal3_d = gal3_q + 3'd1;
                    default: ;
                endcase
                tur_d = tur_yeni;
                if (tur_yeni == 4'(TUR_SAYISI)) begin
                    // Vectors and sayi stay visible for inspection.
                    durum_d = BITTI;
                end else begin
                    durum_d = TOPLA;
                    sag_d   = '0;
                    asagi_d = '0;
                    sira_d  = 2'd1;
                    sayi_d  = lfsr_q;
`ifdef HAMLE_ZAMAN_ASIMI_EN
                    bos_d   = '0;
`endif
                end
            end

            default: durum_d = BOSTA;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum_q <= BOSTA;
            lfsr_q  <= LFSR_TOHUM;
            sag_q   <= '0;
            asagi_q <= '0;
            sayi_q  <= '0;
            sira_q  <= '0;
            tur_q   <= '0;
            skor_q  <= '0;
            gal1_q  <= '0;
            gal2_q  <= '0;
            gal3_q  <= '0;
`ifdef HAMLE_ZAMAN_ASIMI_EN
            bos_q   <= '0;
`endif
        end else begin
            durum_q <= durum_d;
            lfsr_q  <= lfsr_d;
            sag_q   <= sag_d;
            asagi_q <= asagi_d;
            sayi_q  <= sayi_d;
            sira_q  <= sira_d;
            tur_q   <= tur_d;
            skor_q  <= skor_d;
            gal1_q  <= gal1_d;
            gal2_q  <= gal2_d;
            gal3_q  <= gal3_d;
`ifdef HAMLE_ZAMAN_ASIMI_EN
            bos_q   <= bos_d;
`endif
        end
    end

    assign sag_adimlar   = sag_q;
    assign asagi_adimlar = asagi_q;
    assign sayi          = sayi_q;
    assign oyuncu_sira   = sira_q;
    assign tur_gecerli   = (durum_q == DEGERLENDIR);
    assign tur_no        = tur_q;
    assign toplam_skor   = skor_q;
    assign galibiyet1    = gal1_q;
    assign galibiyet2    = gal2_q;
    assign galibiyet3    = gal3_q;
    assign oyun_bitti    = (durum_q == BITTI);

endmodule

// File: tb/tb_hamle_toplayici.sv
// ============================================================================
// tb_hamle_toplayici -- self-checking bench for hamle_toplayici.
//
// Two instances share clock and reset: index 0 plays 4-round games, index 1
// plays 9-round games (to reach the score and win saturation limits). The
// reference model tracks raw totals per game and applies the clamps only when
// forming expectations; hidden numbers come from the precomputed period-15
// sequence of the x^4+x^3+1 LFSR seeded with 4'b1011.
// ============================================================================
module tb_hamle_toplayici;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       basla_s [2];
    logic       hv_s    [2];
    logic [1:0] hs_s    [2];
    logic [1:0] ha_s    [2];
    logic [1:0] kaz_s   [2];
    logic [4:0] puan_s  [2];

    logic [5:0] sag_o   [2];
    logic [5:0] asa_o   [2];
    logic [3:0] sayi_o  [2];
    logic [1:0] sira_o  [2];
    logic       tg_o    [2];
    logic [3:0] tur_o   [2];
    logic [7:0] skor_o  [2];
    logic [2:0] g1_o    [2];
    logic [2:0] g2_o    [2];
    logic [2:0] g3_o    [2];
    logic       bitti_o [2];

    hamle_toplayici #(.TUR_SAYISI(4), .LFSR_TOHUM(4'b1011), .ZAMAN_SINIRI(15)) u_a (
        .clk(clk), .rst(rst), .basla(basla_s[0]), .hamle_gecerli(hv_s[0]),
        .hamle_sag(hs_s[0]), .hamle_asagi(ha_s[0]), .kazanan(kaz_s[0]),
        .toplam_puan(puan_s[0]), .sag_adimlar(sag_o[0]), .asagi_adimlar(asa_o[0]),
        .sayi(sayi_o[0]), .oyuncu_sira(sira_o[0]), .tur_gecerli(tg_o[0]),
        .tur_no(tur_o[0]), .toplam_skor(skor_o[0]), .galibiyet1(g1_o[0]),
        .galibiyet2(g2_o[0]), .galibiyet3(g3_o[0]), .oyun_bitti(bitti_o[0]));

    hamle_toplayici #(.TUR_SAYISI(9), .LFSR_TOHUM(4'b1011), .ZAMAN_SINIRI(15)) u_b (
        .clk(clk), .rst(rst), .basla(basla_s[1]), .hamle_gecerli(hv_s[1]),
        .hamle_sag(hs_s[1]), .hamle_asagi(ha_s[1]), .kazanan(kaz_s[1]),
        .toplam_puan(puan_s[1]), .sag_adimlar(sag_o[1]), .asagi_adimlar(asa_o[1]),
        .sayi(sayi_o[1]), .oyuncu_sira(sira_o[1]), .tur_gecerli(tg_o[1]),
        .tur_no(tur_o[1]), .toplam_skor(skor_o[1]), .galibiyet1(g1_o[1]),
        .galibiyet2(g2_o[1]), .galibiyet3(g3_o[1]), .oyun_bitti(bitti_o[1]));

    // LFSR sequence from seed 1011, shifting left with feedback bit3^bit2.
    logic [3:0] lfsr_tab [15] = '{4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2,
                                  4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5};

    // Clock edges seen since reset was released.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: raw per-game totals, clamped only when compared.
    int         tur_lim [2] = '{4, 9};
    int         m_tur   [2];
    int         m_skor  [2];
    int         m_win   [2][4];
    logic [3:0] m_sayi  [2];
    logic [5:0] m_sag   [2];
    logic [5:0] m_asa   [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Hidden number the DUT should have latched at the edge just passed.
    function automatic logic [3:0] lfsr_now();
        return lfsr_tab[(cyc - 1) % 15];
    endfunction

    task automatic check_zero(input int d, input string tag);
        check({tag, "_sag"},   32'(sag_o[d]),   0);
        check({tag, "_asa"},   32'(asa_o[d]),   0);
        check({tag, "_sayi"},  32'(sayi_o[d]),  0);
        check({tag, "_sira"},  32'(sira_o[d]),  0);
        check({tag, "_tg"},    32'(tg_o[d]),    0);
        check({tag, "_tur"},   32'(tur_o[d]),   0);
        check({tag, "_skor"},  32'(skor_o[d]),  0);
        check({tag, "_g1"},    32'(g1_o[d]),    0);
        check({tag, "_g2"},    32'(g2_o[d]),    0);
        check({tag, "_g3"},    32'(g3_o[d]),    0);
        check({tag, "_bitti"}, 32'(bitti_o[d]), 0);
    endtask

    task automatic check_counts(input int d, input string tag);
        check({tag, "_tur"},  32'(tur_o[d]),  m_tur[d]);
        check({tag, "_skor"}, 32'(skor_o[d]), sat(m_skor[d], 255));
        check({tag, "_g1"},   32'(g1_o[d]),   sat(m_win[d][1], 7));
        check({tag, "_g2"},   32'(g2_o[d]),   sat(m_win[d][2], 7));
        check({tag, "_g3"},   32'(g3_o[d]),   sat(m_win[d][3], 7));
    endtask

    task automatic start_game(input int d, input bit with_move);
        basla_s[d] = 1'b1;
        if (with_move) begin
            hv_s[d] = 1'b1; hs_s[d] = 2'd3; ha_s[d] = 2'd3;
        end
        tick();
        basla_s[d] = 1'b0;
        hv_s[d]    = 1'b0;
        m_tur[d]   = 0;
        m_skor[d]  = 0;
        for (int k = 0; k < 4; k++) m_win[d][k] = 0;
        m_sayi[d]  = lfsr_now();
        check("start_sira",  32'(sira_o[d]),  1);
        check("start_sag",   32'(sag_o[d]),   0);
        check("start_asa",   32'(asa_o[d]),   0);
        check("start_sayi",  32'(sayi_o[d]),  32'(m_sayi[d]));
        check("start_bitti", 32'(bitti_o[d]), 0);
        check_counts(d, "start");
    endtask

    // One full round: three moves with random idle gaps, then evaluation.
    task automatic play_round(input int d, input logic [5:0] sv, input logic [5:0] av,
                              input logic [1:0] kaz, input logic [4:0] puan);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            check("sira_before", 32'(sira_o[d]), i + 1);
            if (i == 2) begin
                kaz_s[d] = kaz; puan_s[d] = puan;
            end
            hs_s[d] = sv[5 - 2*i -: 2];
            ha_s[d] = av[5 - 2*i -: 2];
            hv_s[d] = 1'b1;
            tick();
            hv_s[d] = 1'b0;
            if (i < 2) begin
                check("sira_after", 32'(sira_o[d]), i + 2);
                check("tg_early",   32'(tg_o[d]),   0);
            end
        end
        check("tg_high",    32'(tg_o[d]),   1);
        check("sira_eval",  32'(sira_o[d]), 0);
        check("vec_sag",    32'(sag_o[d]),  32'(sv));
        check("vec_asa",    32'(asa_o[d]),  32'(av));
        check("sayi_round", 32'(sayi_o[d]), 32'(m_sayi[d]));
        tick();
        m_tur[d]++;
        m_skor[d] += int'(puan);
        if (kaz != 2'd0) m_win[d][kaz]++;
        m_sag[d] = sv;
        m_asa[d] = av;
        check("tg_low", 32'(tg_o[d]), 0);
        check_counts(d, "eval");
        if (m_tur[d] == tur_lim[d]) begin
            check("end_bitti", 32'(bitti_o[d]), 1);
            check("end_sag",   32'(sag_o[d]),   32'(sv));
            check("end_sayi",  32'(sayi_o[d]),  32'(m_sayi[d]));
        end else begin
            m_sayi[d] = lfsr_now();
            check("next_sira",  32'(sira_o[d]), 1);
            check("next_sag",   32'(sag_o[d]),  0);
            check("next_asa",   32'(asa_o[d]),  0);
            check("next_sayi",  32'(sayi_o[d]), 32'(m_sayi[d]));
            check("sayi_nz",    32'(sayi_o[d] != 4'd0), 1);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            basla_s[d] = 0; hv_s[d] = 0; hs_s[d] = 0; ha_s[d] = 0;
            kaz_s[d] = 0; puan_s[d] = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero(0, "rst_a");
        check_zero(1, "rst_b");
        rst = 1'b0;
        tick();
        check_zero(0, "bosta");

        // Reset in the middle of collection, after two moves.
        start_game(0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            hv_s[0] = 1'b1; hs_s[0] = 2'd2; ha_s[0] = 2'd1;
            tick();
            hv_s[0] = 1'b0;
        end
        check("pre_rst_sira", 32'(sira_o[0]), 3);
        #2 rst = 1'b1;
        #1;
        check_zero(0, "mid_rst");
        rst = 1'b0;
        hv_s[0] = 1'b1; hs_s[0] = 2'd3; ha_s[0] = 2'd3;
        tick();
        hv_s[0] = 1'b0;
        check("idle_move_sag",  32'(sag_o[0]),  0);
        check("idle_move_sira", 32'(sira_o[0]), 0);

        // Start with a coincident move strobe: only the start takes effect.
        start_game(0, 1'b1);

        // Game A: directed first round, then random moves; winner 3, score 9.
        play_round(0, 6'h2D, 6'h13, 2'd3, 5'd9);
        for (int r = 1; r < 4; r++)
            play_round(0, 6'($urandom), 6'($urandom), 2'd3, 5'd9);
        check("a_skor",  32'(skor_o[0]),  36);
        check("a_g3",    32'(g3_o[0]),    4);
        check("a_g1",    32'(g1_o[0]),    0);
        check("a_g2",    32'(g2_o[0]),    0);
        check("a_tur",   32'(tur_o[0]),   4);
        check("a_bitti", 32'(bitti_o[0]), 1);

        // Moves after the game ends are ignored.
        hv_s[0] = 1'b1; hs_s[0] = ~m_sag[0][1:0]; ha_s[0] = ~m_asa[0][1:0];
        tick();
        hv_s[0] = 1'b0;
        check("bitti_hold_sag", 32'(sag_o[0]), 32'(m_sag[0]));
        check("bitti_hold_asa", 32'(asa_o[0]), 32'(m_asa[0]));

        // Second game on A: counters cleared, random winners and scores.
        start_game(0, 1'b0);
        for (int r = 0; r < 4; r++)
            play_round(0, 6'($urandom), 6'($urandom),
                       2'($urandom_range(0, 3)), 5'($urandom));

        // Game B: nine rounds of maximal score for player 1 -> saturation.
        start_game(1, 1'b0);
        for (int r = 0; r < 9; r++)
            play_round(1, 6'($urandom), 6'($urandom), 2'd1, 5'd31);
        check("b_skor",  32'(skor_o[1]),  255);
        check("b_g1",    32'(g1_o[1]),    7);
        check("b_tur",   32'(tur_o[1]),   9);
        check("b_bitti", 32'(bitti_o[1]), 1);

`ifdef HAMLE_ZAMAN_ASIMI_EN
        // Idle players are skipped with 00/00 after 15 quiet cycles.
        start_game(0, 1'b0);
        hv_s[0] = 1'b1; hs_s[0] = 2'd3; ha_s[0] = 2'd2;
        tick();
        hv_s[0] = 1'b0;
        repeat (14) tick();
        check("to_wait_p2", 32'(sira_o[0]), 2);
        tick();
        check("to_skip_p2",  32'(sira_o[0]), 3);
        check("to_sag_p2",   32'(sag_o[0]),  32'(6'b11_00_00));
        check("to_asa_p2",   32'(asa_o[0]),  32'(6'b10_00_00));
        repeat (14) tick();
        check("to_wait_p3", 32'(sira_o[0]), 3);
        tick();
        check("to_skip_p3", 32'(sira_o[0]), 0);
        check("to_eval",    32'(tg_o[0]),   1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
